// File: rtl/image_buffer_writer.sv
// Ping-pong image writer: streams pixels into one of two BRAM buffers and
// hands each completed buffer to a downstream reader with a start pulse.
module image_buffer_writer #(
  parameter int unsigned PIXEL_SIZE = 8,
  parameter int unsigned NUM_PIXELS = 784,
  parameter logic [31:0] BASE_ADDR1 = 32'hB000_0000,
  parameter logic [31:0] BASE_ADDR2 = 32'hB000_1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PIXEL_SIZE-1:0] pixel_i,
  input  logic                  pixel_valid_i,
  output logic                  stall_o,
  output logic [31:0]           bram_address,
  output logic [31:0]           bram_wdata,
  output logic [3:0]            bram_we,
  output logic                  bram_en,
  output logic                  start_o,
  input  logic                  image_done_i
);

  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMMIT  = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic             r_wbuf;
  logic             r_rbuf;
  logic [1:0]       r_full;
  logic [1:0]       w_full_next;
  logic             r_busy;
  logic             r_start;
  logic             r_bram_en;
  logic [3:0]       r_bram_we;
  logic [31:0]      r_bram_address;
  logic [31:0]      r_bram_wdata;

  logic             w_stall;
  logic             w_accept;
  logic             w_done;
  logic             w_launch;
  logic [31:0]      w_base;
  logic [31:0]      w_wr_addr;

  // Stall is a pure decode of registered state so upstream sees it early.
  assign w_stall   = (r_state != FILL) || r_full[r_wbuf];
  assign w_accept  = pixel_valid_i && !w_stall;
  assign w_done    = image_done_i && r_busy;
  assign w_launch  = r_full[r_rbuf] && !r_busy;
  assign w_base    = r_wbuf ? BASE_ADDR2 : BASE_ADDR1;
  assign w_wr_addr = w_base + 32'({r_count, 2'b00});

  // Full flags after this cycle: reader release and writer commit touch
  // different buffers, so both may land in the same cycle.
  always_comb begin
    w_full_next = r_full;
    if (w_done) begin
      w_full_next[r_rbuf] = 1'b0;
    end
    if (r_state == COMMIT) begin
      w_full_next[r_wbuf] = 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL: begin
        if (w_accept && (r_count == LAST_IDX)) begin
          w_next_state = COMMIT;
        end
      end
      COMMIT: begin
        w_next_state = w_full_next[~r_wbuf] ? BLOCKED : FILL;
      end
      BLOCKED: begin
        if (!w_full_next[r_wbuf]) begin
          w_next_state = FILL;
        end
      end
      default: w_next_state = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Write side: pixel counter, buffer pointer, full flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_wbuf  <= 1'b0;
      r_full  <= 2'b00;
    end else begin
      r_full <= w_full_next;
      if (r_state == COMMIT) begin
        r_count <= '0;
        r_wbuf  <= ~r_wbuf;
      end else if (w_accept) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Read side: the busy flag gates start so it can never fire twice in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rbuf  <= 1'b0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_start <= w_launch;
      if (w_done) begin
        r_busy <= 1'b0;
        r_rbuf <= ~r_rbuf;
      end else if (w_launch) begin
        r_busy <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bram_en      <= 1'b0;
      r_bram_we      <= 4'h0;
      r_bram_address <= '0;
      r_bram_wdata   <= '0;
    end else begin
      r_bram_en <= w_accept;
      r_bram_we <= w_accept ? 4'hF : 4'h0;
      if (w_accept) begin
        r_bram_address <= w_wr_addr;
        r_bram_wdata   <= 32'(pixel_i);
      end
    end
  end

  assign stall_o      = w_stall;
  assign start_o      = r_start;
  assign bram_en      = r_bram_en;
  assign bram_we      = r_bram_we;
  assign bram_address = r_bram_address;
  assign bram_wdata   = r_bram_wdata;

endmodule

// File: tb/tb_image_buffer_writer.sv
// Directed bench for image_buffer_writer: vector table for the opening
// cycles, then hand sequences for commit, blocking, coincident done and reset.
module tb_image_buffer_writer;

  localparam int unsigned NPIX  = 784;
  localparam logic [31:0] BASE1 = 32'hB000_0000;
  localparam logic [31:0] BASE2 = 32'hB000_1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  pixel_i;
  logic        pixel_valid_i;
  logic        stall_o;
  logic [31:0] bram_address;
  logic [31:0] bram_wdata;
  logic [3:0]  bram_we;
  logic        bram_en;
  logic        start_o;
  logic        image_done_i;

  int n_cmp  = 0;
  int n_fail = 0;

  image_buffer_writer #(
    .PIXEL_SIZE (8),
    .NUM_PIXELS (NPIX),
    .BASE_ADDR1 (BASE1),
    .BASE_ADDR2 (BASE2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pixel_i       (pixel_i),
    .pixel_valid_i (pixel_valid_i),
    .stall_o       (stall_o),
    .bram_address  (bram_address),
    .bram_wdata    (bram_wdata),
    .bram_we       (bram_we),
    .bram_en       (bram_en),
    .start_o       (start_o),
    .image_done_i  (image_done_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [7:0]  pix;
    logic        done;
    logic        exp_stall;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_start;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int img, input int i);
    return 8'((i * 7 + img * 13 + 5) & 255);
  endfunction

  // Feeds pixels [from, to) of an image and checks each resulting write.
  task automatic feed(input int img, input logic [31:0] base, input int from,
                      input int to, input bit gaps);
    int g;
    for (int i = from; i < to; i++) begin
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        pixel_valid_i = 1'b0;
        pixel_i       = 8'hEE;
        step();
        chk("gap_en", 32'(bram_en), 32'd0);
      end
      chk("pre_stall", 32'(stall_o), 32'd0);
      pixel_valid_i = 1'b1;
      pixel_i       = pix(img, i);
      step();
      chk("wr_en", 32'(bram_en), 32'd1);
      chk("wr_addr", bram_address, base + 32'(4 * i));
      chk("wr_data", bram_wdata, 32'(pix(img, i)));
      if (i == int'(NPIX) - 1) chk("commit_stall", 32'(stall_o), 32'd1);
    end
    pixel_valid_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_start"}, 32'(start_o), 32'd0);
    chk({tag, "_en"}, 32'(bram_en), 32'd0);
    chk({tag, "_we"}, 32'(bram_we), 32'd0);
    chk({tag, "_addr"}, bram_address, 32'd0);
    chk({tag, "_data"}, bram_wdata, 32'd0);
  endtask

  // Continuous protocol checks: enables agree, start is a single-cycle pulse.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    chk("we_vs_en", 32'(bram_we), bram_en ? 32'hF : 32'h0);
    if (start_o) chk("start_double", 32'(prev_start), 32'd0);
    prev_start <= start_o;
  end

  initial begin
    reset_n       = 1'b0;
    pixel_i       = '0;
    pixel_valid_i = 1'b0;
    image_done_i  = 1'b0;

    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, BASE1 + 32'd0,  32'h11, 1'b0};
    vecs[1] = '{1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 32'd0,          32'd0,  1'b0};
    vecs[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, BASE1 + 32'd4,  32'h33, 1'b0};
    vecs[3] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, BASE1 + 32'd8,  32'hFF, 1'b0};
    vecs[4] = '{1'b0, 8'h44, 1'b1, 1'b0, 1'b0, 32'd0,          32'd0,  1'b0};
    vecs[5] = '{1'b1, 8'h80, 1'b0, 1'b0, 1'b1, BASE1 + 32'd12, 32'h80, 1'b0};

    // Reset state with a valid pixel presented.
    pixel_valid_i = 1'b1;
    pixel_i       = 8'h5A;
    repeat (3) step();
    chk_all_zero("rst");
    pixel_valid_i = 1'b0;
    reset_n       = 1'b1;
    step();

    // Opening vectors, including spurious done pulses with no reader busy.
    for (int v = 0; v < 6; v++) begin
      pixel_valid_i = vecs[v].valid;
      pixel_i       = vecs[v].pix;
      image_done_i  = vecs[v].done;
      step();
      chk($sformatf("vec%0d_stall", v), 32'(stall_o), 32'(vecs[v].exp_stall));
      chk($sformatf("vec%0d_en", v), 32'(bram_en), 32'(vecs[v].exp_en));
      chk($sformatf("vec%0d_start", v), 32'(start_o), 32'(vecs[v].exp_start));
      if (vecs[v].exp_en) begin
        chk($sformatf("vec%0d_addr", v), bram_address, vecs[v].exp_addr);
        chk($sformatf("vec%0d_data", v), bram_wdata, vecs[v].exp_data);
      end
    end
    image_done_i = 1'b0;

    // Image 0 completes into buffer 0; stall only in the commit cycle.
    feed(0, BASE1, 4, NPIX, 1'b0);
    chk("img0_commit_start", 32'(start_o), 32'd0);
    step();
    chk("img0_post_stall", 32'(stall_o), 32'd0);
    chk("img0_start_early", 32'(start_o), 32'd0);
    step();
    chk("img0_start", 32'(start_o), 32'd1);
    step();
    chk("img0_start_end", 32'(start_o), 32'd0);

    // Image 1 with upstream gaps into buffer 1; both buffers end up full.
    feed(1, BASE2, 0, NPIX, 1'b1);
    pixel_valid_i = 1'b1;
    pixel_i       = pix(2, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("blk_stall", 32'(stall_o), 32'd1);
      chk("blk_en", 32'(bram_en), 32'd0);
      chk("blk_start", 32'(start_o), 32'd0);
    end
    image_done_i = 1'b1;
    step();
    image_done_i = 1'b0;
    chk("unblk_stall", 32'(stall_o), 32'd0);
    chk("unblk_en", 32'(bram_en), 32'd0);
    step();
    chk("held_en", 32'(bram_en), 32'd1);
    chk("held_addr", bram_address, BASE1);
    chk("held_data", bram_wdata, 32'(pix(2, 0)));
    chk("img1_start", 32'(start_o), 32'd1);

    // Image 2 commits in the same cycle the reader releases buffer 1.
    feed(2, BASE1, 1, NPIX, 1'b0);
    image_done_i = 1'b1;
    step();
    image_done_i = 1'b0;
    chk("coinc_stall", 32'(stall_o), 32'd0);
    chk("coinc_start_early", 32'(start_o), 32'd0);
    step();
    chk("coinc_start", 32'(start_o), 32'd1);
    step();
    chk("coinc_start_end", 32'(start_o), 32'd0);

    // Partial image 3 into buffer 1, then reset at pixel 400.
    feed(3, BASE2, 0, 400, 1'b1);
    pixel_valid_i = 1'b1;
    pixel_i       = pix(3, 400);
    reset_n       = 1'b0;
    #2;
    chk_all_zero("midrst");
    step();
    chk_all_zero("midrst2");
    pixel_valid_i = 1'b0;
    reset_n       = 1'b1;
    step();
    chk("postrst_stall", 32'(stall_o), 32'd0);
    feed(4, BASE1, 0, 3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("postrst_start", 32'(start_o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
